// File: rtl/image_scan_reader.sv
// Image scan reader: walks a ROWS x COLS image ROM in raster order and
// streams the pixels out through a 2-entry buffer with valid/ready flow
// control. The ROM has one cycle of read latency, so an address issued in
// one cycle is captured, with its tags, on the following edge.
//
// state  | meaning
// IDLE   | waiting for start
// SCAN   | issuing ROM addresses as buffer credit allows
// DRAIN  | every address issued, pixels still buffered or in flight
// DONE   | one cycle, done pulse, then back to IDLE
module image_scan_reader #(
  parameter int IMG_ROWS = 240,
  parameter int IMG_COLS = 320
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [7:0]  rom_row,
  output logic [8:0]  rom_col,
  input  logic [11:0] rom_data,
  output logic [11:0] pix_data,
  output logic [7:0]  pix_row,
  output logic [8:0]  pix_col,
  output logic        pix_eol,
  output logic        pix_last,
  output logic        pix_valid,
  input  logic        pix_ready
);

  localparam logic [7:0] LAST_ROW = 8'(IMG_ROWS - 1);
  localparam logic [8:0] LAST_COL = 9'(IMG_COLS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [7:0]  row_q, row_d;
  logic [8:0]  col_q, col_d;

  // One read can be outstanding at a time (latency 1, at most one issue per
  // cycle), so a single flag tracks it along with the tags of that read.
  logic        inflight_q, inflight_d;
  logic [7:0]  cap_row_q, cap_row_d;
  logic [8:0]  cap_col_q, cap_col_d;
  logic        cap_eol_q, cap_eol_d;
  logic        cap_last_q, cap_last_d;

  // Two-entry buffer: head drives the pixel outputs directly, tail is the
  // second slot.
  logic [1:0]  occ_q, occ_d;
  logic [11:0] head_data_q, head_data_d, tail_data_q, tail_data_d;
  logic [7:0]  head_row_q, head_row_d, tail_row_q, tail_row_d;
  logic [8:0]  head_col_q, head_col_d, tail_col_q, tail_col_d;
  logic        head_eol_q, head_eol_d, tail_eol_q, tail_eol_d;
  logic        head_last_q, head_last_d, tail_last_q, tail_last_d;

  logic        pop;
  logic        push;
  logic [1:0]  occ_after_pop;
  logic        credit_ok;
  logic        issue;
  logic        at_last_col;
  logic        at_last_row;

  // Handshake, credit check and issue decision.
  always_comb begin
    pop           = (occ_q != 2'd0) && pix_ready;
    push          = inflight_q;
    occ_after_pop = occ_q - {1'b0, pop};
    credit_ok     = ({1'b0, occ_after_pop} + {2'b00, inflight_q}) < 3'd2;
    issue         = (state_q == S_SCAN) && credit_ok;
    at_last_col   = (col_q == LAST_COL);
    at_last_row   = (row_q == LAST_ROW);
  end

  // Next-state for the FSM, the address counters and the in-flight tags.
  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    row_d      = row_q;
    col_d      = col_q;
    inflight_d = issue;
    cap_row_d  = cap_row_q;
    cap_col_d  = cap_col_q;
    cap_eol_d  = cap_eol_q;
    cap_last_d = cap_last_q;

    if (issue) begin
      cap_row_d  = row_q;
      cap_col_d  = col_q;
      cap_eol_d  = at_last_col;
      cap_last_d = at_last_col && at_last_row;
      if (at_last_col) begin
        col_d = 9'd0;
        row_d = at_last_row ? 8'd0 : row_q + 8'd1;
      end else begin
        col_d = col_q + 9'd1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SCAN;
          busy_d  = 1'b1;
          row_d   = 8'd0;
          col_d   = 9'd0;
        end
      end
      S_SCAN: begin
        if (issue && at_last_col && at_last_row) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (pop && head_last_q) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Buffer update; a simultaneous push and pop keeps occupancy and order.
  always_comb begin
    occ_d       = occ_q;
    head_data_d = head_data_q;
    head_row_d  = head_row_q;
    head_col_d  = head_col_q;
    head_eol_d  = head_eol_q;
    head_last_d = head_last_q;
    tail_data_d = tail_data_q;
    tail_row_d  = tail_row_q;
    tail_col_d  = tail_col_q;
    tail_eol_d  = tail_eol_q;
    tail_last_d = tail_last_q;

    case ({push, pop})
      2'b10: begin
        occ_d = occ_q + 2'd1;
        if (occ_q == 2'd0) begin
          head_data_d = rom_data;
          head_row_d  = cap_row_q;
          head_col_d  = cap_col_q;
          head_eol_d  = cap_eol_q;
          head_last_d = cap_last_q;
        end else begin
          tail_data_d = rom_data;
          tail_row_d  = cap_row_q;
          tail_col_d  = cap_col_q;
          tail_eol_d  = cap_eol_q;
          tail_last_d = cap_last_q;
        end
      end
      2'b01: begin
        occ_d       = occ_q - 2'd1;
        head_data_d = tail_data_q;
        head_row_d  = tail_row_q;
        head_col_d  = tail_col_q;
        head_eol_d  = tail_eol_q;
        head_last_d = tail_last_q;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          head_data_d = rom_data;
          head_row_d  = cap_row_q;
          head_col_d  = cap_col_q;
          head_eol_d  = cap_eol_q;
          head_last_d = cap_last_q;
        end else begin
          head_data_d = tail_data_q;
          head_row_d  = tail_row_q;
          head_col_d  = tail_col_q;
          head_eol_d  = tail_eol_q;
          head_last_d = tail_last_q;
          tail_data_d = rom_data;
          tail_row_d  = cap_row_q;
          tail_col_d  = cap_col_q;
          tail_eol_d  = cap_eol_q;
          tail_last_d = cap_last_q;
        end
      end
      default: begin
      end
    endcase
  end

  // All state registers; reset abandons any frame in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      row_q       <= 8'd0;
      col_q       <= 9'd0;
      inflight_q  <= 1'b0;
      cap_row_q   <= 8'd0;
      cap_col_q   <= 9'd0;
      cap_eol_q   <= 1'b0;
      cap_last_q  <= 1'b0;
      occ_q       <= 2'd0;
      head_data_q <= 12'd0;
      head_row_q  <= 8'd0;
      head_col_q  <= 9'd0;
      head_eol_q  <= 1'b0;
      head_last_q <= 1'b0;
      tail_data_q <= 12'd0;
      tail_row_q  <= 8'd0;
      tail_col_q  <= 9'd0;
      tail_eol_q  <= 1'b0;
      tail_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      row_q       <= row_d;
      col_q       <= col_d;
      inflight_q  <= inflight_d;
      cap_row_q   <= cap_row_d;
      cap_col_q   <= cap_col_d;
      cap_eol_q   <= cap_eol_d;
      cap_last_q  <= cap_last_d;
      occ_q       <= occ_d;
      head_data_q <= head_data_d;
      head_row_q  <= head_row_d;
      head_col_q  <= head_col_d;
      head_eol_q  <= head_eol_d;
      head_last_q <= head_last_d;
      tail_data_q <= tail_data_d;
      tail_row_q  <= tail_row_d;
      tail_col_q  <= tail_col_d;
      tail_eol_q  <= tail_eol_d;
      tail_last_q <= tail_last_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign rom_row   = row_q;
  assign rom_col   = col_q;
  assign pix_valid = (occ_q != 2'd0);
  assign pix_data  = head_data_q;
  assign pix_row   = head_row_q;
  assign pix_col   = head_col_q;
  assign pix_eol   = head_eol_q;
  assign pix_last  = head_last_q;

endmodule

// File: tb/tb_image_scan_reader.sv
// Bench for image_scan_reader on a 2x3 image: expected pixels are queued
// when a frame is started, and a negedge monitor pops and compares them on
// every handshake.
module tb_image_scan_reader;

  localparam int R = 2;
  localparam int C = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        busy;
  logic        done;
  logic [7:0]  rom_row;
  logic [8:0]  rom_col;
  logic [11:0] rom_data;
  logic [11:0] pix_data;
  logic [7:0]  pix_row;
  logic [8:0]  pix_col;
  logic        pix_eol;
  logic        pix_last;
  logic        pix_valid;
  logic        pix_ready;

  image_scan_reader #(.IMG_ROWS(R), .IMG_COLS(C)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .rom_row(rom_row), .rom_col(rom_col), .rom_data(rom_data),
    .pix_data(pix_data), .pix_row(pix_row), .pix_col(pix_col),
    .pix_eol(pix_eol), .pix_last(pix_last), .pix_valid(pix_valid),
    .pix_ready(pix_ready)
  );

  always #5 clk = ~clk;

  // Image ROM with one cycle of read latency.
  always @(posedge clk) rom_data <= {rom_row[3:0], rom_col[7:0]};

  typedef struct {
    logic [7:0]  row;
    logic [8:0]  col;
    logic [11:0] data;
    logic        eol;
    logic        last;
  } exp_t;

  exp_t sb[$];
  exp_t em;
  int   tests = 0;
  int   fails = 0;
  int   done_count = 0;
  int   done_exp = 0;

  logic        stall_prev = 1'b0;
  logic [11:0] h_data;
  logic [7:0]  h_row;
  logic [8:0]  h_col;
  logic        h_eol, h_last;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_frame();
    exp_t e;
    logic [7:0] rr;
    logic [8:0] cc;
    for (int r = 0; r < R; r++) begin
      for (int c = 0; c < C; c++) begin
        rr     = 8'(r);
        cc     = 9'(c);
        e.row  = rr;
        e.col  = cc;
        e.data = {rr[3:0], cc[7:0]};
        e.eol  = (c == C - 1);
        e.last = (r == R - 1) && (c == C - 1);
        sb.push_back(e);
      end
    end
  endtask

  // Leaves the bench 1 time unit after the edge that sampled start.
  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit rnd);
    bit got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (rnd) pix_ready = 1'($urandom_range(0, 1));
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      tests++;
      fails++;
      $display("FAIL done_timeout: no done within %0d cycles", budget);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_valid"}, pix_valid, 0);
    chk({tag, "_rom_row"}, rom_row, 0);
    chk({tag, "_rom_col"}, rom_col, 0);
    chk({tag, "_pix_data"}, pix_data, 0);
    chk({tag, "_pix_row"}, pix_row, 0);
    chk({tag, "_pix_col"}, pix_col, 0);
    chk({tag, "_eol"}, pix_eol, 0);
    chk({tag, "_last"}, pix_last, 0);
  endtask

  // Scoreboard monitor: stall stability, in-order pixel check, done count.
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("stall_valid", pix_valid, 1);
        chk("stall_data", pix_data, h_data);
        chk("stall_tags", {h_row, h_col, h_eol, h_last}, {pix_row, pix_col, pix_eol, pix_last});
      end
      if (pix_valid && pix_ready) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL extra_pixel: got row %0d col %0d with nothing expected", pix_row, pix_col);
        end else begin
          em = sb.pop_front();
          chk("pix_row", pix_row, em.row);
          chk("pix_col", pix_col, em.col);
          chk("pix_data", pix_data, em.data);
          chk("pix_eol", pix_eol, em.eol);
          chk("pix_last", pix_last, em.last);
        end
      end
      stall_prev = pix_valid && !pix_ready;
      h_data = pix_data;
      h_row  = pix_row;
      h_col  = pix_col;
      h_eol  = pix_eol;
      h_last = pix_last;
      if (done) begin
        done_count++;
        chk("done_all_pixels_seen", sb.size(), 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    rst = 1'b1;
    start = 1'b0;
    pix_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b0;

    // Full-rate frame: timing of every pixel and of done.
    pix_ready = 1'b1;
    push_frame();
    done_exp++;
    pulse_start();
    chk("t2_busy_after_start", busy, 1);
    chk("t2_valid_c1", pix_valid, 0);
    @(posedge clk); #1;
    chk("t2_valid_c2", pix_valid, 0);
    @(posedge clk); #1;
    chk("t2_first_valid", pix_valid, 1);
    chk("t2_first_rc", {pix_row, pix_col}, {8'd0, 9'd0});
    for (int k = 1; k < R * C; k++) begin
      @(posedge clk); #1;
      chk("t2_stream_valid", pix_valid, 1);
      chk("t2_stream_rc", {pix_row, pix_col}, {8'(k / C), 9'(k % C)});
      chk("t2_stream_busy", busy, 1);
    end
    @(posedge clk); #1;
    chk("t2_done", done, 1);
    chk("t2_busy_low", busy, 0);
    chk("t2_valid_low", pix_valid, 0);
    @(posedge clk); #1;
    chk("t2_done_one_cycle", done, 0);

    // Downstream stalled right after start: only two addresses go out.
    pix_ready = 1'b0;
    push_frame();
    done_exp++;
    pulse_start();
    repeat (20) @(posedge clk);
    #1;
    chk("t3_rom_row_frozen", rom_row, 0);
    chk("t3_rom_col_frozen", rom_col, 2);
    chk("t3_valid", pix_valid, 1);
    chk("t3_head_rc", {pix_row, pix_col}, {8'd0, 9'd0});
    pix_ready = 1'b1;
    wait_done(50, 1'b0);
    repeat (2) @(posedge clk);

    // Random backpressure.
    push_frame();
    done_exp++;
    pulse_start();
    wait_done(300, 1'b1);
    pix_ready = 1'b1;
    repeat (2) @(posedge clk);

    // start during SCAN and during DONE must be ignored.
    push_frame();
    done_exp++;
    pulse_start();
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(50, 1'b0);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("t5_idle_busy", busy, 0);
    chk("t5_idle_valid", pix_valid, 0);
    chk("t5_done_count", done_count, done_exp);

    // Reset in the middle of row 1, then a clean frame.
    push_frame();
    pulse_start();
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (pix_valid && pix_row == 8'd1) begin
        found = 1'b1;
        break;
      end
    end
    chk("t6_reached_row1", found, 1);
    #2 rst = 1'b1;
    #1;
    chk_reset_outputs("t6_async");
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("t6_idle_busy", busy, 0);
    chk("t6_idle_valid", pix_valid, 0);
    chk("t6_no_done", done_count, done_exp);
    push_frame();
    done_exp++;
    pulse_start();
    wait_done(50, 1'b0);
    repeat (3) @(posedge clk);
    #1;

    chk("final_done_count", done_count, done_exp);
    chk("final_sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
